// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, ALU encodings, control-word layout and
// the ID/EX pipeline register record.
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam int CTRL_REG_WRITE   = 9;
    localparam int CTRL_MEM_READ    = 8;
    localparam int CTRL_MEM_WRITE   = 7;
    localparam int CTRL_BRANCH      = 6;
    localparam int CTRL_JAL         = 5;
    localparam int CTRL_JALR        = 4;
    localparam int CTRL_ALU_SRC_IMM = 3;
    localparam int CTRL_LUI         = 2;
    localparam int CTRL_AUIPC       = 1;
    localparam int CTRL_ILLEGAL     = 0;
    localparam int CTRL_W           = 10;

    // Field order matches the CTRL_* indices above, MSB first.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jal;
        logic jalr;
        logic alu_src_imm;
        logic lui;
        logic auipc;
        logic illegal;
    } ctrl_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   imm;
        alu_op_e           alu_op;
        ctrl_t             ctrl;
        logic [2:0]        funct3;
    } id_ex_t;

    // alt selects SUB over ADD and SRA over SRL (instruction bit 30).
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID/EX pipeline register bundle from decode toward execute.
interface id_stage_if;
    import rv32_pkg::*;

    logic              valid_E;
    logic [XLEN-1:0]   PcE;
    logic [XLEN-1:0]   rs1_data_E;
    logic [XLEN-1:0]   rs2_data_E;
    logic [REG_AW-1:0] rs1_E;
    logic [REG_AW-1:0] rs2_E;
    logic [REG_AW-1:0] rd_E;
    logic [XLEN-1:0]   imm_E;
    logic [3:0]        alu_op_E;
    logic [CTRL_W-1:0] ctrl_E;
    logic [2:0]        funct3_E;

    modport master (
        output valid_E, PcE, rs1_data_E, rs2_data_E, rs1_E, rs2_E, rd_E,
               imm_E, alu_op_E, ctrl_E, funct3_E
    );

    modport slave (
        input  valid_E, PcE, rs1_data_E, rs2_data_E, rs1_E, rs2_E, rd_E,
               imm_E, alu_op_E, ctrl_E, funct3_E
    );

endinterface

// File: rtl/reg_file.sv
// 32x32 architectural register file: two combinational read ports with
// write-through bypass, one write port, x0 hardwired to zero.
module reg_file
    import rv32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] i_rs1_addr,
    input  logic [REG_AW-1:0] i_rs2_addr,
    output logic [XLEN-1:0]   o_rs1_data,
    output logic [XLEN-1:0]   o_rs2_data,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [XLEN-1:0]   i_wd
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_en;

    assign w_wr_en = i_we && (i_rd != '0);

    // NOTE: the array is reset because the core relies on every register
    // reading zero out of reset; this rules out a plain RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_rd] <= i_wd;
        end
    end

    always_comb begin
        o_rs1_data = r_regs[i_rs1_addr];
        o_rs2_data = r_regs[i_rs2_addr];
        if (w_wr_en && (i_rd == i_rs1_addr)) o_rs1_data = i_wd;
        if (w_wr_en && (i_rd == i_rs2_addr)) o_rs2_data = i_wd;
        if (i_rs1_addr == '0) o_rs1_data = '0;
        if (i_rs2_addr == '0) o_rs2_data = '0;
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: field/control decode, register read, load-use hazard
// detection and the ID/EX pipeline register.
module id_stage
    import rv32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       i_InstrD,
    input  logic [XLEN-1:0]   i_PcD,
    input  logic              i_flush,
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic              o_stall,
    id_stage_if.master        o_id_ex
);

    logic [6:0]        w_opcode;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [REG_AW-1:0] w_rd;
    logic              w_valid;
    logic              w_rs1_used;
    logic              w_rs2_used;
    logic              w_hazard;
    logic              w_issue;
    logic [XLEN-1:0]   w_rs1_data;
    logic [XLEN-1:0]   w_rs2_data;
    logic [XLEN-1:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    id_ex_t            w_dec;
    id_ex_t            r_id_ex;

    assign w_opcode = i_InstrD[6:0];
    assign w_rd     = i_InstrD[11:7];
    assign w_rs1    = i_InstrD[19:15];
    assign w_rs2    = i_InstrD[24:20];
    assign w_valid  = (i_InstrD != '0);

    assign w_imm_i = {{20{i_InstrD[31]}}, i_InstrD[31:20]};
    assign w_imm_s = {{20{i_InstrD[31]}}, i_InstrD[31:25], i_InstrD[11:7]};
    assign w_imm_b = {{19{i_InstrD[31]}}, i_InstrD[31], i_InstrD[7],
                      i_InstrD[30:25], i_InstrD[11:8], 1'b0};
    assign w_imm_u = {i_InstrD[31:12], 12'b0};
    assign w_imm_j = {{11{i_InstrD[31]}}, i_InstrD[31], i_InstrD[19:12],
                      i_InstrD[20], i_InstrD[30:21], 1'b0};

    reg_file u_reg_file (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rs1_addr (w_rs1),
        .i_rs2_addr (w_rs2),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .i_we       (i_wb_we),
        .i_rd       (i_wb_rd),
        .i_wd       (i_wb_data)
    );

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a value unassigned and infers a latch.
    always_comb begin
        w_dec          = '0;
        w_dec.valid    = w_valid;
        w_dec.pc       = i_PcD;
        w_dec.rs1_data = w_rs1_data;
        w_dec.rs2_data = w_rs2_data;
        w_dec.rs1      = w_rs1;
        w_dec.rs2      = w_rs2;
        w_dec.rd       = w_rd;
        w_dec.funct3   = i_InstrD[14:12];
        w_dec.alu_op   = ALU_ADD;
        w_rs1_used     = 1'b1;
        w_rs2_used     = 1'b0;

        case (w_opcode)
            OPC_LUI: begin
                w_dec.ctrl.reg_write   = 1'b1;
                w_dec.ctrl.alu_src_imm = 1'b1;
                w_dec.ctrl.lui         = 1'b1;
                w_dec.alu_op           = ALU_PASSB;
                w_dec.imm              = w_imm_u;
                w_rs1_used             = 1'b0;
            end
            OPC_AUIPC: begin
                w_dec.ctrl.reg_write   = 1'b1;
                w_dec.ctrl.alu_src_imm = 1'b1;
                w_dec.ctrl.auipc       = 1'b1;
                w_dec.imm              = w_imm_u;
                w_rs1_used             = 1'b0;
            end
            OPC_JAL: begin
                w_dec.ctrl.reg_write = 1'b1;
                w_dec.ctrl.jal       = 1'b1;
                w_dec.imm            = w_imm_j;
                w_rs1_used           = 1'b0;
            end
            OPC_JALR: begin
                w_dec.ctrl.reg_write   = 1'b1;
                w_dec.ctrl.jalr        = 1'b1;
                w_dec.ctrl.alu_src_imm = 1'b1;
                w_dec.imm              = w_imm_i;
            end
            OPC_BRANCH: begin
                w_dec.ctrl.branch = 1'b1;
                w_dec.imm         = w_imm_b;
                w_rs2_used        = 1'b1;
                // Branches compare: equality via SUB, ordering via SLT/SLTU.
                case (i_InstrD[14:13])
                    2'b10:   w_dec.alu_op = ALU_SLT;
                    2'b11:   w_dec.alu_op = ALU_SLTU;
                    default: w_dec.alu_op = ALU_SUB;
                endcase
            end
            OPC_LOAD: begin
                w_dec.ctrl.reg_write   = 1'b1;
                w_dec.ctrl.mem_read    = 1'b1;
                w_dec.ctrl.alu_src_imm = 1'b1;
                w_dec.imm              = w_imm_i;
            end
            OPC_STORE: begin
                w_dec.ctrl.mem_write   = 1'b1;
                w_dec.ctrl.alu_src_imm = 1'b1;
                w_dec.imm              = w_imm_s;
                w_rs2_used             = 1'b1;
            end
            OPC_OP_IMM: begin
                w_dec.ctrl.reg_write   = 1'b1;
                w_dec.ctrl.alu_src_imm = 1'b1;
                w_dec.imm              = w_imm_i;
                w_dec.alu_op = alu_decode(i_InstrD[14:12],
                                          i_InstrD[30] && (i_InstrD[14:12] == 3'b101));
            end
            OPC_OP: begin
                w_dec.ctrl.reg_write = 1'b1;
                w_dec.alu_op         = alu_decode(i_InstrD[14:12], i_InstrD[30]);
                w_rs2_used           = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                w_dec.imm = w_imm_i;
            end
            default: begin
                w_dec.ctrl.illegal = 1'b1;
            end
        endcase

        if (w_rd == '0) w_dec.ctrl.reg_write = 1'b0;
    end

    assign w_hazard = w_valid && i_ex_mem_read && (i_ex_rd != '0) &&
                      (((i_ex_rd == w_rs1) && w_rs1_used) ||
                       ((i_ex_rd == w_rs2) && w_rs2_used));

    // Gating with rst_n drops the stall immediately when reset asserts.
    assign o_stall = rst_n && !i_flush && w_hazard;
    assign w_issue = w_valid && !i_flush && !w_hazard;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_ex <= '0;
        end else begin
            r_id_ex <= w_issue ? w_dec : '0;
        end
    end

    assign o_id_ex.valid_E    = r_id_ex.valid;
    assign o_id_ex.PcE        = r_id_ex.pc;
    assign o_id_ex.rs1_data_E = r_id_ex.rs1_data;
    assign o_id_ex.rs2_data_E = r_id_ex.rs2_data;
    assign o_id_ex.rs1_E      = r_id_ex.rs1;
    assign o_id_ex.rs2_E      = r_id_ex.rs2;
    assign o_id_ex.rd_E       = r_id_ex.rd;
    assign o_id_ex.imm_E      = r_id_ex.imm;
    assign o_id_ex.alu_op_E   = r_id_ex.alu_op;
    assign o_id_ex.ctrl_E     = r_id_ex.ctrl;
    assign o_id_ex.funct3_E   = r_id_ex.funct3;

endmodule

// File: tb/tb_id_stage.sv
// Directed scoreboard bench for id_stage: expected ID/EX contents are queued
// when an instruction is presented and compared one edge later.
module tb_id_stage;
    import rv32_pkg::*;

    localparam logic [9:0] C_RW    = 10'h200;
    localparam logic [9:0] C_MW    = 10'h080;
    localparam logic [9:0] C_BR    = 10'h040;
    localparam logic [9:0] C_JAL   = 10'h020;
    localparam logic [9:0] C_IMM   = 10'h008;
    localparam logic [9:0] C_LUI   = 10'h004;
    localparam logic [9:0] C_ILL   = 10'h001;

    typedef struct {
        string       tag;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [9:0]  ctrl;
        logic [2:0]  f3;
        logic        dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_InstrD;
    logic [31:0] i_PcD;
    logic        i_flush;
    logic        i_ex_mem_read;
    logic [4:0]  i_ex_rd;
    logic        i_wb_we;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic        o_stall;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    id_stage_if u_if ();

    id_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_InstrD      (i_InstrD),
        .i_PcD         (i_PcD),
        .i_flush       (i_flush),
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rd       (i_ex_rd),
        .i_wb_we       (i_wb_we),
        .i_wb_rd       (i_wb_rd),
        .i_wb_data     (i_wb_data),
        .o_stall       (o_stall),
        .o_id_ex       (u_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [31:0] instr,
                                input logic [31:0] pc, input logic [31:0] rs1d,
                                input logic [31:0] rs2d, input logic [31:0] imm,
                                input logic [3:0] alu, input logic [9:0] ctrl,
                                input logic dp);
        exp_t e;
        e.tag  = tag;
        e.valid = 1'b1;
        e.pc   = pc;
        e.rs1d = rs1d;
        e.rs2d = rs2d;
        e.rs1  = instr[19:15];
        e.rs2  = instr[24:20];
        e.rd   = instr[11:7];
        e.f3   = instr[14:12];
        e.imm  = imm;
        e.alu  = alu;
        e.ctrl = ctrl;
        e.dp   = dp;
        return e;
    endfunction

    function automatic exp_t bubble(input string tag);
        exp_t e;
        e = mk(tag, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 10'h0, 1'b1);
        e.valid = 1'b0;
        return e;
    endfunction

    task automatic compare_out(input exp_t e);
        check({e.tag, ".valid"},  {31'b0, u_if.valid_E}, {31'b0, e.valid});
        check({e.tag, ".pc"},     u_if.PcE,              e.pc);
        check({e.tag, ".rs1d"},   u_if.rs1_data_E,       e.rs1d);
        check({e.tag, ".rs2d"},   u_if.rs2_data_E,       e.rs2d);
        check({e.tag, ".rs1"},    {27'b0, u_if.rs1_E},   {27'b0, e.rs1});
        check({e.tag, ".rs2"},    {27'b0, u_if.rs2_E},   {27'b0, e.rs2});
        check({e.tag, ".rd"},     {27'b0, u_if.rd_E},    {27'b0, e.rd});
        check({e.tag, ".ctrl"},   {22'b0, u_if.ctrl_E},  {22'b0, e.ctrl});
        check({e.tag, ".funct3"}, {29'b0, u_if.funct3_E},{29'b0, e.f3});
        if (e.dp) begin
            check({e.tag, ".imm"}, u_if.imm_E,             e.imm);
            check({e.tag, ".alu"}, {28'b0, u_if.alu_op_E}, {28'b0, e.alu});
        end
    endtask

    // Queue the expectation, let one edge pass, then score the ID/EX register.
    task automatic step(input exp_t e);
        exp_t got;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        compare_out(got);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        i_InstrD = instr;
        i_PcD    = pc;
        #1;
    endtask

    task automatic check_stall(input string tag, input logic exp);
        check(tag, {31'b0, o_stall}, {31'b0, exp});
    endtask

    initial begin
        rst_n = 1'b1;
        i_InstrD = 32'h0; i_PcD = 32'h0; i_flush = 1'b0;
        i_ex_mem_read = 1'b0; i_ex_rd = 5'd0;
        i_wb_we = 1'b0; i_wb_rd = 5'd0; i_wb_data = 32'h0;
        #2 rst_n = 1'b0;
        i_InstrD = 32'h0050_0093;
        i_PcD    = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        compare_out(bubble("reset"));
        check_stall("reset.stall", 1'b0);

        // addi x1,x0,5 issues on the first edge after release.
        rst_n = 1'b1;
        step(mk("addi", 32'h0050_0093, 32'h100, 32'h0, 32'h0, 32'd5, ALU_ADD, C_RW | C_IMM, 1'b1));

        // Same-cycle write-back to x3 is bypassed into add x4,x3,x0.
        i_wb_we = 1'b1; i_wb_rd = 5'd3; i_wb_data = 32'hDEAD_BEEF;
        drive(32'h0001_8233, 32'h104);
        step(mk("bypass", 32'h0001_8233, 32'h104, 32'hDEAD_BEEF, 32'h0, 32'h0, ALU_ADD, C_RW, 1'b1));

        // Write to x0 must not be visible, neither bypassed nor stored.
        i_wb_rd = 5'd0; i_wb_data = 32'h1;
        drive(32'h0000_0233, 32'h108);
        step(mk("x0_bypass", 32'h0000_0233, 32'h108, 32'h0, 32'h0, 32'h0, ALU_ADD, C_RW, 1'b1));
        i_wb_we = 1'b0;
        drive(32'h0030_02B3, 32'h10C);
        step(mk("x0_read", 32'h0030_02B3, 32'h10C, 32'h0, 32'hDEAD_BEEF, 32'h0, ALU_ADD, C_RW, 1'b1));

        // Load-use on x5 stalls sub x6,x5,x7; x5 is written during the stall.
        i_ex_mem_read = 1'b1; i_ex_rd = 5'd5;
        i_wb_we = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'h55;
        drive(32'h4072_8333, 32'h110);
        check_stall("loaduse.stall", 1'b1);
        step(bubble("loaduse.bubble"));
        i_ex_mem_read = 1'b0; i_wb_we = 1'b0;
        drive(32'h4072_8333, 32'h110);
        check_stall("loaduse.release", 1'b0);
        step(mk("loaduse.issue", 32'h4072_8333, 32'h110, 32'h55, 32'h0, 32'h0, ALU_SUB, C_RW, 1'b1));

        // lui writes x5 but reads nothing, so a load into x5 must not stall it.
        i_ex_mem_read = 1'b1; i_ex_rd = 5'd5;
        drive(32'h1234_52B7, 32'h114);
        check_stall("lui.stall", 1'b0);
        step(mk("lui", 32'h1234_52B7, 32'h114, 32'h0, 32'hDEAD_BEEF, 32'h1234_5000,
                ALU_PASSB, C_RW | C_IMM | C_LUI, 1'b1));

        // Flush wins over a simultaneous load-use hazard.
        i_flush = 1'b1;
        drive(32'h4072_8333, 32'h118);
        check_stall("flush.stall", 1'b0);
        step(bubble("flush"));
        i_flush = 1'b0; i_ex_mem_read = 1'b0;

        drive(32'hFE00_0CE3, 32'h11C);
        step(mk("beq", 32'hFE00_0CE3, 32'h11C, 32'h0, 32'h0, 32'hFFFF_FFF8, ALU_SUB, C_BR, 1'b1));
        drive(32'h0030_2623, 32'h120);
        step(mk("sw", 32'h0030_2623, 32'h120, 32'h0, 32'hDEAD_BEEF, 32'd12, ALU_ADD, C_MW | C_IMM, 1'b1));
        drive(32'h0100_00EF, 32'h124);
        step(mk("jal", 32'h0100_00EF, 32'h124, 32'h0, 32'h0, 32'd16, ALU_ADD, C_RW | C_JAL, 1'b1));
        drive(NOP_INSTR, 32'h128);
        step(mk("nop_rd0", NOP_INSTR, 32'h128, 32'h0, 32'h0, 32'h0, ALU_ADD, C_IMM, 1'b1));
        drive(32'h0000_008B, 32'h12C);
        step(mk("illegal", 32'h0000_008B, 32'h12C, 32'h0, 32'h0, 32'h0, ALU_ADD, C_ILL, 1'b0));

        // An all-zero word is a bubble and never raises a hazard.
        i_ex_mem_read = 1'b1; i_ex_rd = 5'd5;
        drive(32'h0, 32'h130);
        check_stall("empty.stall", 1'b0);
        step(bubble("empty"));

        // Reset asserted while stalling clears everything at once.
        drive(32'h0003_02B3, 32'h134);
        step(mk("pre_rst", 32'h0003_02B3, 32'h134, 32'h0, 32'h0, 32'h0, ALU_ADD, C_RW, 1'b1));
        drive(32'h4072_8333, 32'h138);
        check_stall("midrst.before", 1'b1);
        rst_n = 1'b0;
        #1;
        check_stall("midrst.stall", 1'b0);
        compare_out(bubble("midrst"));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        i_ex_mem_read = 1'b0;
        drive(32'h0030_02B3, 32'h13C);
        step(mk("post_rst", 32'h0030_02B3, 32'h13C, 32'h0, 32'h0, 32'h0, ALU_ADD, C_RW, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
